// File: rtl/counter_arb_if.sv
// counter_arb_if -- handshake bundle between requesters and counter_arb.
//   master : drives req, len, abort; observes gnt/busy/cnt/done/done_id/aborted
//   slave  : the arbiter side (counter_arb)
//   req     [NREQ]        level request per requester
//   len     [NREQ*WIDTH]  terminal count per requester, slice i = [i*WIDTH +: WIDTH]
//   abort                 kill the current run
//   gnt     [NREQ]        one-hot owner of the shared counter
//   busy                  counter is running
//   cnt     [WIDTH]       shared counter value
//   done / done_id        completion pulse and owner index
//   aborted               pulse when a run ends without completion
interface counter_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic                  abort;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      cnt;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic                  aborted;

    modport master (
        output req, len, abort,
        input  gnt, busy, cnt, done, done_id, aborted
    );

    modport slave (
        input  req, len, abort,
        output gnt, busy, cnt, done, done_id, aborted
    );
endinterface

// File: rtl/counter_arb.sv
// counter_arb -- round-robin arbiter for one shared up-counter.
// A winner owns the counter from 0 up to its latched len, then the block
// pulses done (or aborted when the run is cut short) and re-arbitrates.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    counter_arb_if.slave (req/len/abort in, gnt/busy/cnt/done/done_id/aborted out)
module counter_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    counter_arb_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [WIDTH-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_max;
    logic [IDW-1:0]    r_win;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_done_id;
    logic              r_done;
    logic              r_aborted;
    logic              r_busy;

    logic              w_found;
    logic [IDW-1:0]    w_win;
    logic [IDW:0]      w_idx;
    logic [WIDTH-1:0]  w_len_sel;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [IDW-1:0]    w_ptr_nxt;
    logic              w_stop;

    // Round-robin search: first requester at or above r_ptr, wrapping.
    // One extra index bit keeps ptr+k from overflowing before the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ))
                w_idx = w_idx - (IDW+1)'(NREQ);
            if (!w_found && bus.req[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
    end

    // Terminal count of the winner, selected by a mux rather than a
    // variable part-select.
    always_comb begin
        w_len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i))
                w_len_sel = bus.len[i*WIDTH +: WIDTH];
        end
    end

    assign w_gnt_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_ptr_nxt = (r_win == IDW'(NREQ-1)) ? '0 : r_win + 1'b1;

    // Dropping the owner's request is treated like an explicit abort.
    assign w_stop = bus.abort | ~bus.req[r_win];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_max     <= '0;
            r_win     <= '0;
            r_ptr     <= '0;
            r_done_id <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_RUN;
                        r_win   <= w_win;
                        r_gnt   <= w_gnt_nxt;
                        r_max   <= w_len_sel;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Abort is checked first so it wins over completion.
                    if (w_stop) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                        r_ptr     <= w_ptr_nxt;
                    end else if (r_cnt == r_max) begin
                        // cnt holds its final value through DONE.
                        r_state   <= S_DONE;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_done_id <= r_win;
                        r_ptr     <= w_ptr_nxt;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = r_busy;
    assign bus.cnt     = r_cnt;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.aborted = r_aborted;

endmodule

// File: tb/tb_counter_arb.sv
// tb_counter_arb -- self-checking bench for counter_arb (NREQ=4, WIDTH=8).
// Directed table of per-cycle vectors, hand-written multi-cycle sequences
// (round-robin order, len=255 wrap, reset mid-run) and a randomized run
// compared against a transaction-level reference model.
module tb_counter_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    counter_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    counter_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] len;
        logic        abort;
        logic [3:0]  gnt;
        logic [7:0]  cnt;
        logic        busy;
        logic        done;
        logic [1:0]  did;
        logic        abt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] r, logic [31:0] l, logic a, logic [3:0] g,
                                logic [7:0] c, logic b, logic d, logic [1:0] id, logic ab);
        vec_t v;
        v.req = r; v.len = l; v.abort = a; v.gnt = g; v.cnt = c;
        v.busy = b; v.done = d; v.did = id; v.abt = ab;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.len   = '0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (at negedges) until gnt is nonzero; expiry counts as a failure.
    task automatic wait_gnt(string name, int limit);
        int n;
        n = 0;
        while (bus.gnt == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.gnt == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for grant after %0d cycles", name, limit);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner-based view: who holds the counter, how far it has counted,
    // and whether we sit in the one-cycle completion slot.
    int m_owner, m_cnt, m_lim, m_ptr, m_did;
    bit m_indone, m_done, m_abt;

    function automatic void model_reset();
        m_owner = -1; m_cnt = 0; m_lim = 0; m_ptr = 0; m_did = 0;
        m_indone = 0; m_done = 0; m_abt = 0;
    endfunction

    function automatic void model_step(logic [3:0] r, logic [31:0] l, logic a);
        m_done = 0;
        m_abt  = 0;
        if (m_indone) begin
            m_indone = 0;
            m_cnt    = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (m_owner < 0 && r[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_lim = (l >> (m_owner * WIDTH)) & 32'hFF;
                m_cnt = 0;
            end
        end else if (a || !r[m_owner]) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_cnt   = 0;
            m_abt   = 1;
        end else if (m_cnt == m_lim) begin
            m_ptr    = (m_owner + 1) % NREQ;
            m_did    = m_owner;
            m_owner  = -1;
            m_indone = 1;
            m_done   = 1;
        end else begin
            m_cnt = (m_cnt + 1) % 256;
        end
    endfunction

    initial begin
        logic [3:0]  exp_g;
        logic [31:0] rl;
        int          n, bad;
        checks = 0;
        errors = 0;

        // ---------------- reset state ----------------
        rst_n = 1'b0; bus.req = '0; bus.len = '0; bus.abort = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {bus.gnt, bus.cnt, bus.busy, bus.done, bus.done_id, bus.aborted}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        // single request len0=3
        tbl.push_back(mk(4'b0001, 32'h0000_0003, 0, 4'b0001, 8'd0, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0001, 32'h0000_0003, 0, 4'b0001, 8'd1, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0001, 32'h0000_0003, 0, 4'b0001, 8'd2, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0001, 32'h0000_0003, 0, 4'b0001, 8'd3, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0001, 32'h0000_0003, 0, 4'b0000, 8'd3, 0, 1, 2'd0, 0));
        tbl.push_back(mk(4'b0000, 32'h0000_0003, 0, 4'b0000, 8'd0, 0, 0, 2'd0, 0));
        // abort at cnt=5, len2=10; len changes mid-run are ignored
        tbl.push_back(mk(4'b0100, 32'h000A_0000, 0, 4'b0100, 8'd0, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0100, 32'h0001_0000, 0, 4'b0100, 8'd1, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0100, 32'h0002_0000, 0, 4'b0100, 8'd2, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0100, 32'h0000_0000, 0, 4'b0100, 8'd3, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0100, 32'h000A_0000, 0, 4'b0100, 8'd4, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0100, 32'h000A_0000, 0, 4'b0100, 8'd5, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0100, 32'h000A_0000, 1, 4'b0000, 8'd0, 0, 0, 2'd0, 1));
        tbl.push_back(mk(4'b0000, 32'h0000_0000, 0, 4'b0000, 8'd0, 0, 0, 2'd0, 0));
        // abort in the same cycle cnt reaches len3=2
        tbl.push_back(mk(4'b1000, 32'h0200_0000, 0, 4'b1000, 8'd0, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b1000, 32'h0200_0000, 0, 4'b1000, 8'd1, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b1000, 32'h0200_0000, 0, 4'b1000, 8'd2, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b1000, 32'h0200_0000, 1, 4'b0000, 8'd0, 0, 0, 2'd0, 1));
        tbl.push_back(mk(4'b0000, 32'h0000_0000, 0, 4'b0000, 8'd0, 0, 0, 2'd0, 0));
        // abort in IDLE ignored
        tbl.push_back(mk(4'b0000, 32'h0000_0000, 1, 4'b0000, 8'd0, 0, 0, 2'd0, 0));
        // owner drops req -> treated as abort
        tbl.push_back(mk(4'b0001, 32'h0000_0005, 0, 4'b0001, 8'd0, 1, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0000, 32'h0000_0005, 0, 4'b0000, 8'd0, 0, 0, 2'd0, 1));
        tbl.push_back(mk(4'b0000, 32'h0000_0000, 0, 4'b0000, 8'd0, 0, 0, 2'd0, 0));

        foreach (tbl[i]) begin
            bus.req = tbl[i].req; bus.len = tbl[i].len; bus.abort = tbl[i].abort;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.gnt, bus.cnt, bus.busy, bus.done, bus.aborted} !==
                {tbl[i].gnt, tbl[i].cnt, tbl[i].busy, tbl[i].done, tbl[i].abt} ||
                (tbl[i].done && bus.done_id !== tbl[i].did)) begin
                errors++;
                $display("FAIL vec%0d: got gnt=%b cnt=%0d busy=%b done=%b id=%0d abt=%b expected gnt=%b cnt=%0d busy=%b done=%b id=%0d abt=%b",
                         i, bus.gnt, bus.cnt, bus.busy, bus.done, bus.done_id, bus.aborted,
                         tbl[i].gnt, tbl[i].cnt, tbl[i].busy, tbl[i].done, tbl[i].did, tbl[i].abt);
            end
        end
        bus.abort = 1'b0;

        // ---------------- round-robin, all req held, len=0 ----------------
        do_reset();
        bus.req = 4'b1111; bus.len = '0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rr_wait", 10);
            exp_g = 4'b0001 << (k % 4);
            check("rr_gnt", bus.gnt, exp_g);
            @(negedge clk);
            check("rr_done", {bus.gnt, bus.done, bus.done_id}, {4'b0000, 1'b1, 2'(k % 4)});
            @(negedge clk);
            check("rr_gap_idle", bus.gnt, 4'b0000);
        end
        bus.req = '0;

        // ---------------- len=255 wrap ----------------
        do_reset();
        bus.req = 4'b0001; bus.len = 32'h0000_00FF;
        wait_gnt("wrap_wait", 5);
        n = 0; bad = 0;
        while (bus.gnt != 0 && n < 300) begin
            if (bus.cnt != 8'(n)) bad++;
            @(negedge clk);
            n++;
        end
        check("wrap_gnt_cycles", n, 256);
        check("wrap_cnt_seq_errs", bad, 0);
        check("wrap_done", {bus.done, bus.done_id, bus.cnt, bus.busy}, {1'b1, 2'd0, 8'hFF, 1'b0});
        bus.req = '0;

        // ---------------- reset mid-run ----------------
        do_reset();
        bus.req = 4'b0001; bus.len = 32'h0000_000A;
        wait_gnt("rst_wait", 5);
        n = 0;
        while (bus.cnt != 8'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_cnt4", bus.cnt, 8'd4);
        rst_n = 1'b0;
        #1;
        check("rst_async_clear",
              {bus.gnt, bus.cnt, bus.busy, bus.done, bus.done_id, bus.aborted}, '0);
        @(negedge clk);
        check("rst_no_pulse", {bus.done, bus.aborted}, 2'b00);
        rst_n = 1'b1;
        bus.req = 4'b1010;
        @(posedge clk);
        @(negedge clk);
        check("rst_first_gnt", bus.gnt, 4'b0010);
        bus.req = '0;

        // ---------------- randomized vs model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
            rl = '0;
            for (int i = 0; i < NREQ; i++) rl[i*8 +: 8] = 8'($urandom_range(0, 12));
            bus.len   = rl;
            bus.abort = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            model_step(bus.req, bus.len, bus.abort);
            @(negedge clk);
            exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            checks++;
            if ({bus.gnt, bus.cnt, bus.busy, bus.done, bus.aborted} !==
                {exp_g, 8'(m_cnt), (m_owner >= 0), m_done, m_abt} ||
                (m_done && bus.done_id !== 2'(m_did))) begin
                errors++;
                $display("FAIL rand%0d: got gnt=%b cnt=%0d busy=%b done=%b id=%0d abt=%b expected gnt=%b cnt=%0d done=%b id=%0d abt=%b",
                         c, bus.gnt, bus.cnt, bus.busy, bus.done, bus.done_id, bus.aborted,
                         exp_g, m_cnt, m_done, m_did, m_abt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
